// File: rtl/chip_ctrl_reg_pkg.sv
`default_nettype none
// ============================================================================
// chip_ctrl_reg_pkg
// Register map, field positions and shared types of the chip-control block.
// Rev 1.0
// ============================================================================
package chip_ctrl_reg_pkg;

  localparam logic [11:0] ADDR_INFO        = 12'h000;
  localparam logic [11:0] ADDR_CLKDIV      = 12'h010;
  localparam logic [11:0] ADDR_STATUS      = 12'h014;
  localparam logic [11:0] ADDR_PADMUX_BASE = 12'h100;

  localparam int PADS_PER_REG       = 16;
  localparam int DIV_WIDTH_MAX      = 8;
  localparam int CLKDIV_EN_BIT      = 8;
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_TIMEOUT_BIT = 1;

  typedef struct packed {
    logic                     en;
    logic [DIV_WIDTH_MAX-1:0] div;
  } clkdiv_cfg_t;

  function automatic int padmux_regs(input int npads);
    return (npads + PADS_PER_REG - 1) / PADS_PER_REG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_req_handshake.sv
`default_nettype none
// ============================================================================
// clkdiv_req_handshake
// Divider update request registers with valid/ack handshake and ack timeout.
// Rev 1.0
// ============================================================================
module clkdiv_req_handshake
  import chip_ctrl_reg_pkg::*;
#(
  parameter int          ACK_TIMEOUT = 255,
  parameter clkdiv_cfg_t CFG_RST     = '{en: 1'b1, div: 8'd1}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  clkdiv_cfg_t i_start_cfg,
  input  clkdiv_cfg_t i_commit_cfg,
  input  logic        i_ack,
  output clkdiv_cfg_t o_req_cfg,
  output logic        o_valid,
  output logic        o_done,
  output logic        o_err
);

  localparam int            CW          = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] c_cnt_limit = CW'(ACK_TIMEOUT);

  clkdiv_cfg_t   r_req;
  logic          r_valid;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_done;
  logic          w_err;

  // Saturating count of waited cycles; an ack in the limit cycle still wins.
  assign w_cnt_next = (r_cnt == c_cnt_limit) ? r_cnt : r_cnt + CW'(1);
  assign w_done     = r_valid & i_ack;
  assign w_err      = r_valid & ~i_ack & (w_cnt_next == c_cnt_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= CFG_RST;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_req   <= i_start_cfg;
      r_valid <= 1'b1;
      r_cnt   <= '0;
    end else if (r_valid) begin
      if (w_done) begin
        r_valid <= 1'b0;
      end else begin
        r_cnt <= w_cnt_next;
        if (w_err) begin
          r_valid <= 1'b0;
          r_req   <= i_commit_cfg;
        end
      end
    end
  end

  assign o_req_cfg = r_req;
  assign o_valid   = r_valid;
  assign o_done    = w_done;
  assign o_err     = w_err;

endmodule
`default_nettype wire

// File: rtl/apb_chip_ctrl_regs.sv
`default_nettype none
// ============================================================================
// apb_chip_ctrl_regs
// APB chip-control registers: pad-mux selects and handshaked clock divider.
// Rev 1.0
// ============================================================================
module apb_chip_ctrl_regs
  import chip_ctrl_reg_pkg::*;
#(
  parameter int          NPADS       = 48,
  parameter int          DIV_WIDTH   = 8,
  parameter int          DIV_RST     = 1,
  parameter int          ACK_TIMEOUT = 255,
  parameter logic [31:0] INFO_VAL    = 32'h0
) (
  input  logic                 soc_clk_i,
  input  logic                 soc_rstn_synced_i,
  input  logic [11:0]          paddr_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [31:0]          pwdata_i,
  input  logic [3:0]           pstrb_i,
  input  logic [2:0]           pprot_i,
  output logic [31:0]          prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic [2*NPADS-1:0]   padmux_o,
  output logic [DIV_WIDTH-1:0] clkdiv_o,
  output logic                 clkdiv_en_o,
  output logic                 clkdiv_valid_o,
  input  logic                 clkdiv_ack_i
);

  localparam int PADMUX_REGS = padmux_regs(NPADS);
  localparam int PW          = 2 * NPADS;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_ACK = 2'd1;
  localparam logic [1:0] S_RESP     = 2'd2;

  localparam logic [DIV_WIDTH_MAX-1:0] c_div_mask = DIV_WIDTH_MAX'((1 << DIV_WIDTH) - 1);
  localparam clkdiv_cfg_t c_cfg_rst = '{en: 1'b1, div: DIV_WIDTH_MAX'(DIV_RST) & c_div_mask};
  localparam logic [9:0] c_pad_base = ADDR_PADMUX_BASE[11:2];
  localparam logic [9:0] c_pad_end  = c_pad_base + 10'(PADMUX_REGS);

  logic [1:0]    r_state, w_state_next;
  logic [PW-1:0] r_padmux;
  clkdiv_cfg_t   r_commit;
  logic          r_timeout;
  logic          r_resp_err;

  logic [9:0]  w_word, w_pad_idx;
  logic        w_access, w_idle_acc, w_mapped;
  logic        w_hit_info, w_hit_clkdiv, w_hit_status, w_hit_pad;
  logic        w_div_wr, w_wr;
  clkdiv_cfg_t w_new_cfg, w_req_cfg;
  logic        w_hs_valid, w_hs_done, w_hs_err;
  logic [31:0] w_pad_rd, w_rdata;
  logic        w_unused;

  assign w_unused = ^{pprot_i, paddr_i[1:0]};

  assign w_word       = paddr_i[11:2];
  assign w_pad_idx    = w_word - c_pad_base;
  assign w_hit_info   = (w_word == ADDR_INFO[11:2]);
  assign w_hit_clkdiv = (w_word == ADDR_CLKDIV[11:2]);
  assign w_hit_status = (w_word == ADDR_STATUS[11:2]);
  assign w_hit_pad    = (w_word >= c_pad_base) && (w_word < c_pad_end);
  assign w_mapped     = w_hit_info | w_hit_clkdiv | w_hit_status | w_hit_pad;

  assign w_access   = psel_i & penable_i;
  assign w_idle_acc = (r_state == S_IDLE) & w_access;
  // An all-zero-strobe divider write has nothing to offer, so it skips the handshake.
  assign w_div_wr   = w_idle_acc & pwrite_i & w_hit_clkdiv & (|pstrb_i);
  assign w_wr       = w_idle_acc & pwrite_i & ~w_div_wr & w_mapped;

  always_comb begin
    w_new_cfg = r_commit;
    if (pstrb_i[0]) w_new_cfg.div = pwdata_i[DIV_WIDTH_MAX-1:0] & c_div_mask;
    if (pstrb_i[1]) w_new_cfg.en  = pwdata_i[CLKDIV_EN_BIT];
  end

  clkdiv_req_handshake #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CFG_RST     (c_cfg_rst)
  ) u_clkdiv_hs (
    .clk          (soc_clk_i),
    .rst_n        (soc_rstn_synced_i),
    .i_start      (w_div_wr),
    .i_start_cfg  (w_new_cfg),
    .i_commit_cfg (r_commit),
    .i_ack        (clkdiv_ack_i),
    .o_req_cfg    (w_req_cfg),
    .o_valid      (w_hs_valid),
    .o_done       (w_hs_done),
    .o_err        (w_hs_err)
  );

  always_ff @(posedge soc_clk_i or negedge soc_rstn_synced_i) begin
    if (!soc_rstn_synced_i) begin
      r_padmux <= '0;
    end else if (w_wr && w_hit_pad) begin
      for (int i = 0; i < PW; i++) begin
        if (w_pad_idx == 10'(i / 32) && pstrb_i[(i % 32) / 8]) r_padmux[i] <= pwdata_i[i % 32];
      end
    end
  end

  always_ff @(posedge soc_clk_i or negedge soc_rstn_synced_i) begin
    if (!soc_rstn_synced_i) begin
      r_commit   <= c_cfg_rst;
      r_timeout  <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_hs_done) r_commit <= w_req_cfg;
      if (w_hs_err) begin
        r_timeout <= 1'b1;
      end else if (w_wr && w_hit_status && pstrb_i[0] && pwdata_i[STATUS_TIMEOUT_BIT]) begin
        r_timeout <= 1'b0;
      end
      if (w_hs_done || w_hs_err) r_resp_err <= w_hs_err;
    end
  end

  always_comb begin
    w_pad_rd = '0;
    for (int i = 0; i < PW; i++) begin
      if (w_pad_idx == 10'(i / 32)) w_pad_rd[i % 32] = r_padmux[i];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit_info) begin
      w_rdata = INFO_VAL;
    end else if (w_hit_clkdiv) begin
      w_rdata[DIV_WIDTH_MAX-1:0] = r_commit.div;
      w_rdata[CLKDIV_EN_BIT]     = r_commit.en;
    end else if (w_hit_status) begin
      w_rdata[STATUS_BUSY_BIT]    = (r_state != S_IDLE);
      w_rdata[STATUS_TIMEOUT_BIT] = r_timeout;
    end else if (w_hit_pad) begin
      w_rdata = w_pad_rd;
    end
  end

  always_ff @(posedge soc_clk_i or negedge soc_rstn_synced_i) begin
    if (!soc_rstn_synced_i) r_state <= S_IDLE;
    else                    r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_div_wr) w_state_next = S_WAIT_ACK;
      S_WAIT_ACK: if (w_hs_done || w_hs_err) w_state_next = S_RESP;
      S_RESP:     w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Response is gated by the access phase so a master that dropped psel sees nothing.
  always_comb begin
    prdata_o  = '0;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access && !w_div_wr) begin
          pready_o  = 1'b1;
          pslverr_o = ~w_mapped;
          if (!pwrite_i && w_mapped) prdata_o = w_rdata;
        end
      end
      S_RESP: begin
        if (w_access) begin
          pready_o  = 1'b1;
          pslverr_o = r_resp_err;
        end
      end
      default: ;
    endcase
  end

  assign padmux_o       = r_padmux;
  assign clkdiv_o       = w_req_cfg.div[DIV_WIDTH-1:0];
  assign clkdiv_en_o    = w_req_cfg.en;
  assign clkdiv_valid_o = w_hs_valid;

endmodule
`default_nettype wire

// File: tb/tb_apb_chip_ctrl_regs.sv
`default_nettype none
// ============================================================================
// tb_apb_chip_ctrl_regs
// Directed and randomized APB accesses checked against a register-level model.
// Rev 1.0
// ============================================================================
module tb_apb_chip_ctrl_regs;

  // 40 pads leaves the last PADMUX register half populated.
  localparam int NPADS = 40;
  localparam int PW    = 2 * NPADS;
  localparam int NREGS = (NPADS + 15) / 16;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [11:0]   paddr = '0;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0]   pwdata = '0;
  logic [3:0]    pstrb = '0;
  logic [2:0]    pprot = '0;
  logic          ack = 1'b0;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic [PW-1:0] padmux;
  logic [7:0]    clkdiv_div;
  logic          clkdiv_en_o, clkdiv_valid_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pad [0:NREGS-1];
  logic [8:0]  m_cfg;
  logic        m_tmo;

  apb_chip_ctrl_regs #(
    .NPADS(NPADS), .DIV_WIDTH(8), .DIV_RST(1), .ACK_TIMEOUT(TMO), .INFO_VAL(32'h0)
  ) dut (
    .soc_clk_i(clk), .soc_rstn_synced_i(rst_n), .paddr_i(paddr), .psel_i(psel),
    .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .pprot_i(pprot), .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .padmux_o(padmux), .clkdiv_o(clkdiv_div), .clkdiv_en_o(clkdiv_en_o),
    .clkdiv_valid_o(clkdiv_valid_o), .clkdiv_ack_i(ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic logic [31:0] pad_mask(input int k);
    logic [31:0] m;
    for (int b = 0; b < 32; b++) m[b] = ((32 * k + b) < PW);
    return m;
  endfunction

  function automatic logic [PW-1:0] exp_padvec();
    logic [PW-1:0] v;
    for (int i = 0; i < PW; i++) v[i] = m_pad[i / 32][i % 32];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREGS; k++) m_pad[k] = '0;
    m_cfg = 9'h101;
    m_tmo = 1'b0;
  endtask

  task automatic apb(input logic [11:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                     input int ack_after, output logic [31:0] rd, output logic er, output int waits,
                     output int vc, output logic [8:0] seen, output logic stable);
    bit got;
    rd = '0; er = 1'b0; waits = 0; vc = 0; seen = '0; stable = 1'b1; got = 1'b0;
    @(posedge clk); #1;
    paddr = a; pwrite = w; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (clkdiv_valid_o) begin
        vc++;
        if (vc == 1) seen = {clkdiv_en_o, clkdiv_div};
        else if ({clkdiv_en_o, clkdiv_div} !== seen) stable = 1'b0;
      end
      ack = (ack_after > 0) && clkdiv_valid_o && (vc == ack_after);
      if (pready) begin
        got = 1'b1; rd = prdata; er = pslverr;
      end else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL apb_no_pready addr=%0h observed=pready0 expected=pready1", a);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; ack = 1'b0;
  endtask

  task automatic reg_read(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic er; int wt, vc; logic [8:0] sn; logic st;
    apb(a, 1'b0, 32'h0, 4'h0, 0, rd, er, wt, vc, sn, st);
    chk(tag, rd, exp);
    chk({tag, "_waits"}, wt, 0);
    chk({tag, "_err"}, er, 1'b0);
  endtask

  task automatic div_write(input string tag, input logic [31:0] d, input logic [3:0] s, input int ack_after);
    logic [31:0] rd; logic er; int wt, vc; logic [8:0] sn; logic st;
    logic [8:0] req;
    int exp_v;
    req = merge({23'h0, m_cfg}, d, s) & 32'h1FF;
    exp_v = (ack_after >= 1 && ack_after <= TMO) ? ack_after : TMO;
    apb(12'h010, 1'b1, d, s, ack_after, rd, er, wt, vc, sn, st);
    chk({tag, "_valid_cycles"}, vc, exp_v);
    chk({tag, "_waits"}, wt, exp_v + 1);
    chk({tag, "_req"}, sn, req);
    chk({tag, "_stable"}, st, 1'b1);
    if (ack_after >= 1 && ack_after <= TMO) begin
      m_cfg = req;
      chk({tag, "_err"}, er, 1'b0);
    end else begin
      m_tmo = 1'b1;
      chk({tag, "_err"}, er, 1'b1);
    end
    chk({tag, "_valid_low"}, clkdiv_valid_o, 1'b0);
    chk({tag, "_out"}, {clkdiv_en_o, clkdiv_div}, m_cfg);
    reg_read({tag, "_rb"}, 12'h010, {23'h0, m_cfg});
  endtask

  initial begin
    logic [31:0] rd, d;
    logic er, st, flag;
    logic [8:0] sn;
    logic [3:0] s;
    int wt, vc, k;
    bit wr;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_padmux", padmux, '0);
    chk("rst_valid", clkdiv_valid_o, 1'b0);
    chk("rst_div_out", {clkdiv_en_o, clkdiv_div}, 9'h101);
    chk("rst_pready_idle", pready, 1'b0);
    reg_read("rst_pad0", 12'h100, 32'h0);
    reg_read("rst_clkdiv", 12'h010, 32'h101);
    reg_read("rst_status", 12'h014, 32'h0);
    reg_read("rst_info", 12'h000, 32'h0);

    // Partial-strobe pad write and the half-populated last register
    apb(12'h104, 1'b1, 32'hFFFF_FFFF, 4'b0011, 0, rd, er, wt, vc, sn, st);
    m_pad[1] = merge(m_pad[1], 32'hFFFF_FFFF, 4'b0011) & pad_mask(1);
    chk("pad1_waits", wt, 0);
    chk("pad1_err", er, 1'b0);
    chk("pad1_bits", padmux[63:32], 32'h0000_FFFF);
    apb(12'h108, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, rd, er, wt, vc, sn, st);
    m_pad[2] = merge(m_pad[2], 32'hFFFF_FFFF, 4'hF) & pad_mask(2);
    reg_read("pad2_partial", 12'h108, 32'h0000_FFFF);
    chk("pad_vec", padmux, exp_padvec());

    // Randomized pad-mux traffic, including the unmapped register just past the last one
    for (int n = 0; n < 60; n++) begin
      k  = int'($urandom_range(0, NREGS));
      wr = bit'($urandom_range(0, 1));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      apb(12'(12'h100 + 4 * k), wr, d, s, 0, rd, er, wt, vc, sn, st);
      chk("rnd_pad_waits", wt, 0);
      if (k == NREGS) begin
        chk("rnd_unmapped_err", er, 1'b1);
        chk("rnd_unmapped_rd", rd, 32'h0);
      end else begin
        chk("rnd_pad_err", er, 1'b0);
        if (wr) m_pad[k] = merge(m_pad[k], d, s) & pad_mask(k);
        else chk("rnd_pad_rd", rd, m_pad[k]);
      end
      chk("rnd_pad_vec", padmux, exp_padvec());
    end

    // Divider handshake: directed cases
    div_write("div_ack3", 32'h105, 4'b0011, 3);
    div_write("div_tmo", 32'h120, 4'b0011, 0);
    reg_read("status_tmo", 12'h014, 32'h2);
    apb(12'h014, 1'b1, 32'h2, 4'h1, 0, rd, er, wt, vc, sn, st);
    m_tmo = 1'b0;
    reg_read("status_w1c", 12'h014, 32'h0);
    div_write("div_ack_at_limit", 32'h0AB, 4'b0001, TMO);
    div_write("div_same_value", {23'h0, m_cfg}, 4'b0011, 2);

    // Divider handshake: randomized values, strobes and ack delays
    for (int n = 0; n < 10; n++) begin
      div_write("rnd_div", $urandom, 4'($urandom_range(1, 15)), int'($urandom_range(0, TMO)));
      reg_read("rnd_status", 12'h014, {30'h0, m_tmo, 1'b0});
    end
    apb(12'h014, 1'b1, 32'h2, 4'h1, 0, rd, er, wt, vc, sn, st);
    m_tmo = 1'b0;

    // Unmapped access and stray ack
    apb(12'h0F0, 1'b0, 32'h0, 4'h0, 0, rd, er, wt, vc, sn, st);
    chk("unmapped_waits", wt, 0);
    chk("unmapped_err", er, 1'b1);
    chk("unmapped_rd", rd, 32'h0);
    ack = 1'b1;
    flag = 1'b0;
    repeat (4) begin
      @(negedge clk);
      flag = flag | clkdiv_valid_o;
    end
    ack = 1'b0;
    chk("stray_ack_valid", flag, 1'b0);
    chk("stray_ack_out", {clkdiv_en_o, clkdiv_div}, m_cfg);
    reg_read("stray_ack_rb", 12'h010, {23'h0, m_cfg});

    // Master drops psel while the handshake is outstanding
    @(posedge clk); #1;
    paddr = 12'h010; pwrite = 1'b1; pwdata = 32'h133; pstrb = 4'b0011; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("drop_valid", clkdiv_valid_o, 1'b1);
    ack = 1'b1;
    flag = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    flag = flag | pready;
    repeat (2) begin
      @(negedge clk);
      flag = flag | pready;
    end
    chk("drop_no_pready", flag, 1'b0);
    m_cfg = 9'h133;
    reg_read("drop_commit", 12'h010, 32'h133);

    // Reset in the middle of a handshake
    @(posedge clk); #1;
    paddr = 12'h010; pwrite = 1'b1; pwdata = 32'h1AA; pstrb = 4'b0011; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mid_pre_valid", clkdiv_valid_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", clkdiv_valid_o, 1'b0);
    chk("rst_mid_out", {clkdiv_en_o, clkdiv_div}, 9'h101);
    chk("rst_mid_padmux", padmux, '0);
    psel = 1'b0; penable = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    reg_read("post_rst_clkdiv", 12'h010, 32'h101);
    reg_read("post_rst_status", 12'h014, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
